lzw_dict_ctrl: RTL and testbench

Next-generation LZW dictionary store, parametrised in code width, symbol width and depth. The block owns dictionary storage and the code-assignment counter, and self-initialises literal entries after reset or on clear. It exposes a 1-cycle-latency read port, a valid/ready insert port with automatic code assignment, and full and variable-code-width status. It sits between the LZW encoder/decoder FSM and the output bit-packer.

---
 rtl/lzw_pkg.sv | 31 +++
 rtl/lzw_dict_ctrl_if.sv | 37 +++
 rtl/lzw_dict_mem.sv | 23 ++
 rtl/lzw_dict_ctrl.sv | 146 ++++++++++++++
 tb/tb_lzw_dict_ctrl.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lzw_pkg.sv
// Shared types, default widths and helpers for the LZW dictionary store.
package lzw_pkg;

    localparam int unsigned DEF_CHAR_WIDTH = 8;
    localparam int unsigned DEF_CODE_WIDTH = 12;
    localparam int unsigned DEF_DEPTH      = 4096;
    localparam int unsigned LITERALS       = 2 ** DEF_CHAR_WIDTH;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        FULL
    } dict_state_t;

    typedef struct packed {
        logic                      valid;
        logic [DEF_CODE_WIDTH-1:0] prefix;
        logic [DEF_CHAR_WIDTH-1:0] chr;
    } dict_entry_t;

    // Emit width for a code count: min(max_width, floor(log2(n)) + 1).
    function automatic int unsigned emit_width(input int unsigned n, input int unsigned max_width);
        int unsigned msb;
        msb = 0;
        for (int i = 0; i < 32; i++) begin
            if (n[i]) msb = unsigned'(i);
        end
        return (msb + 1 > max_width) ? max_width : msb + 1;
    endfunction

endpackage

// File: rtl/lzw_dict_ctrl_if.sv
// Bus between the LZW coder FSM (master) and the dictionary store (slave).
interface lzw_dict_ctrl_if #(
    parameter int unsigned CHAR_WIDTH = lzw_pkg::DEF_CHAR_WIDTH,
    parameter int unsigned CODE_WIDTH = lzw_pkg::DEF_CODE_WIDTH
);
    localparam int unsigned CbWidth = $clog2(CODE_WIDTH + 1);

    logic                  clear_i;
    logic                  init_done_o;
    logic                  rd_en_i;
    logic [CODE_WIDTH-1:0] rd_addr_i;
    logic [CODE_WIDTH-1:0] rd_prefix_o;
    logic [CHAR_WIDTH-1:0] rd_char_o;
    logic                  rd_hit_o;
    logic                  ins_valid_i;
    logic                  ins_ready_o;
    logic [CODE_WIDTH-1:0] ins_prefix_i;
    logic [CHAR_WIDTH-1:0] ins_char_i;
    logic                  ins_done_o;
    logic [CODE_WIDTH-1:0] ins_code_o;
    logic [CODE_WIDTH:0]   next_code_o;
    logic [CbWidth-1:0]    code_bits_o;
    logic                  full_o;

    modport master (
        output clear_i, rd_en_i, rd_addr_i, ins_valid_i, ins_prefix_i, ins_char_i,
        input  init_done_o, rd_prefix_o, rd_char_o, rd_hit_o, ins_ready_o, ins_done_o,
               ins_code_o, next_code_o, code_bits_o, full_o
    );

    modport slave (
        input  clear_i, rd_en_i, rd_addr_i, ins_valid_i, ins_prefix_i, ins_char_i,
        output init_done_o, rd_prefix_o, rd_char_o, rd_hit_o, ins_ready_o, ins_done_o,
               ins_code_o, next_code_o, code_bits_o, full_o
    );

endinterface

// File: rtl/lzw_dict_mem.sv
// Dictionary storage: one sync write port, one sync read port, read-before-write, no reset.
module lzw_dict_mem #(
    parameter int unsigned ENTRY_WIDTH = 21,
    parameter int unsigned DEPTH       = 4096,
    parameter int unsigned ADDR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   we_i,
    input  logic [ADDR_WIDTH-1:0]  waddr_i,
    input  logic [ENTRY_WIDTH-1:0] wdata_i,
    input  logic                   re_i,
    input  logic [ADDR_WIDTH-1:0]  raddr_i,
    output logic [ENTRY_WIDTH-1:0] rdata_o
);
    logic [ENTRY_WIDTH-1:0] mem [DEPTH];

    // Both ports update with NBAs, so a same-cycle read sees the old contents.
    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/lzw_dict_ctrl.sv
// LZW dictionary controller: self-initialising store, code assignment, width/full status.
module lzw_dict_ctrl
    import lzw_pkg::*;
#(
    parameter int unsigned CHAR_WIDTH = DEF_CHAR_WIDTH,
    parameter int unsigned CODE_WIDTH = DEF_CODE_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH
) (
    input logic           clk,
    input logic           rst,
    lzw_dict_ctrl_if.slave bus
);
    localparam int unsigned NumLiterals = 2 ** CHAR_WIDTH;
    localparam int unsigned EntryWidth  = 1 + CODE_WIDTH + CHAR_WIDTH;
    localparam int unsigned CbWidth     = $clog2(CODE_WIDTH + 1);
    localparam int unsigned MemAw       = $clog2(DEPTH);

    localparam logic [CODE_WIDTH:0]   FirstCode = (CODE_WIDTH + 1)'(NumLiterals);
    localparam logic [CODE_WIDTH:0]   DepthCode = (CODE_WIDTH + 1)'(DEPTH);
    localparam logic [CODE_WIDTH-1:0] LastAddr  = CODE_WIDTH'(DEPTH - 1);
    localparam logic [CODE_WIDTH-1:0] LitLimit  = CODE_WIDTH'(NumLiterals);
    localparam logic [CbWidth-1:0]    FirstBits = CbWidth'(CHAR_WIDTH + 1);

    dict_state_t           state_q, state_d;
    logic [CODE_WIDTH-1:0] init_ptr_q, init_ptr_d;
    logic [CODE_WIDTH:0]   next_code_q, next_code_d;
    logic [CbWidth-1:0]    code_bits_q, code_bits_d;
    logic                  ins_done_q, ins_done_d;
    logic [CODE_WIDTH-1:0] ins_code_q, ins_code_d;
    logic                  rd_live_q;

    logic                  ins_ready;
    logic                  ins_accept;
    logic                  mem_we;
    logic [MemAw-1:0]      mem_waddr;
    logic [EntryWidth-1:0] mem_wdata;
    logic [EntryWidth-1:0] mem_rdata;

    lzw_dict_mem #(
        .ENTRY_WIDTH (EntryWidth),
        .DEPTH       (DEPTH),
        .ADDR_WIDTH  (MemAw)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .re_i    (bus.rd_en_i),
        .raddr_i (bus.rd_addr_i[MemAw-1:0]),
        .rdata_o (mem_rdata)
    );

    // A clear in the same cycle wins over an insert, so readiness drops with it.
    assign ins_ready  = (state_q == RUN) && !bus.clear_i;
    assign ins_accept = bus.ins_valid_i && ins_ready;

    // Next-state: INIT walk, insert code assignment, clear override, emit width.
    always_comb begin
        state_d     = state_q;
        init_ptr_d  = init_ptr_q;
        next_code_d = next_code_q;
        ins_done_d  = 1'b0;
        ins_code_d  = ins_code_q;
        mem_we      = 1'b0;
        mem_waddr   = '0;
        mem_wdata   = '0;

        unique case (state_q)
            INIT: begin
                mem_we    = 1'b1;
                mem_waddr = init_ptr_q[MemAw-1:0];
                if (init_ptr_q < LitLimit) begin
                    mem_wdata = {1'b1, {CODE_WIDTH{1'b0}}, init_ptr_q[CHAR_WIDTH-1:0]};
                end
                if (init_ptr_q == LastAddr) begin
                    state_d    = RUN;
                    init_ptr_d = '0;
                end else begin
                    init_ptr_d = init_ptr_q + 1'b1;
                end
            end
            RUN: begin
                if (ins_accept) begin
                    mem_we      = 1'b1;
                    mem_waddr   = next_code_q[MemAw-1:0];
                    mem_wdata   = {1'b1, bus.ins_prefix_i, bus.ins_char_i};
                    ins_done_d  = 1'b1;
                    ins_code_d  = next_code_q[CODE_WIDTH-1:0];
                    next_code_d = next_code_q + 1'b1;
                    if (next_code_d == DepthCode) state_d = FULL;
                end
            end
            FULL: begin
            end
            default: state_d = INIT;
        endcase

        if (bus.clear_i) begin
            state_d     = INIT;
            init_ptr_d  = '0;
            next_code_d = FirstCode;
            ins_done_d  = 1'b0;
        end

        code_bits_d = CbWidth'(emit_width(32'(next_code_d), CODE_WIDTH));
    end

    // State, counters and insert status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT;
            init_ptr_q  <= '0;
            next_code_q <= FirstCode;
            code_bits_q <= FirstBits;
            ins_done_q  <= 1'b0;
            ins_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            init_ptr_q  <= init_ptr_d;
            next_code_q <= next_code_d;
            code_bits_q <= code_bits_d;
            ins_done_q  <= ins_done_d;
            ins_code_q  <= ins_code_d;
        end
    end

    // Qualifies the held read data: zero during INIT or for codes beyond DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_live_q <= 1'b0;
        end else if (bus.rd_en_i) begin
            rd_live_q <= (state_q != INIT) && ({1'b0, bus.rd_addr_i} < DepthCode);
        end
    end

    assign {bus.rd_hit_o, bus.rd_prefix_o, bus.rd_char_o} = rd_live_q ? mem_rdata : '0;

    assign bus.init_done_o = (state_q != INIT);
    assign bus.ins_ready_o = ins_ready;
    assign bus.full_o      = (state_q == FULL);
    assign bus.ins_done_o  = ins_done_q;
    assign bus.ins_code_o  = ins_code_q;
    assign bus.next_code_o = next_code_q;
    assign bus.code_bits_o = code_bits_q;

endmodule

// File: tb/tb_lzw_dict_ctrl.sv
// Self-checking bench for lzw_dict_ctrl: default instance plus a DEPTH=260 instance.
module tb_lzw_dict_ctrl;
    import lzw_pkg::*;

    localparam int unsigned CW = DEF_CODE_WIDTH;
    localparam int unsigned HW = DEF_CHAR_WIDTH;
    localparam int DA = DEF_DEPTH;
    localparam int DB = 260;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    lzw_dict_ctrl_if #(.CHAR_WIDTH(HW), .CODE_WIDTH(CW)) bus_a ();
    lzw_dict_ctrl_if #(.CHAR_WIDTH(HW), .CODE_WIDTH(CW)) bus_b ();

    lzw_dict_ctrl #(.CHAR_WIDTH(HW), .CODE_WIDTH(CW), .DEPTH(DA)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    lzw_dict_ctrl #(.CHAR_WIDTH(HW), .CODE_WIDTH(CW), .DEPTH(DB)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: inserted entries by code; literals are implicit.
    dict_entry_t dict_m [int];
    int exp_next;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic dict_entry_t exp_entry(input int code, input int depth);
        dict_entry_t e;
        e = '0;
        if (code >= depth) return e;
        if (code < int'(LITERALS)) begin
            e.valid = 1'b1;
            e.chr   = code[HW-1:0];
            return e;
        end
        if (dict_m.exists(code)) return dict_m[code];
        return e;
    endfunction

    function automatic int cb_model(input int n);
        int w;
        w = $clog2(n + 1);
        return (w > int'(CW)) ? int'(CW) : w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_a(input int addr, input string tag, input bit in_init);
        dict_entry_t e;
        bus_a.rd_en_i   = 1'b1;
        bus_a.rd_addr_i = CW'(addr);
        tick();
        bus_a.rd_en_i = 1'b0;
        e = in_init ? '0 : exp_entry(addr, DA);
        check({tag, ".hit"}, 32'(bus_a.rd_hit_o), 32'(e.valid));
        check({tag, ".prefix"}, 32'(bus_a.rd_prefix_o), 32'(e.prefix));
        check({tag, ".char"}, 32'(bus_a.rd_char_o), 32'(e.chr));
    endtask

    task automatic rd_b(input int addr, input string tag);
        dict_entry_t e;
        bus_b.rd_en_i   = 1'b1;
        bus_b.rd_addr_i = CW'(addr);
        tick();
        bus_b.rd_en_i = 1'b0;
        e = exp_entry(addr, DB);
        check({tag, ".hit"}, 32'(bus_b.rd_hit_o), 32'(e.valid));
        check({tag, ".prefix"}, 32'(bus_b.rd_prefix_o), 32'(e.prefix));
        check({tag, ".char"}, 32'(bus_b.rd_char_o), 32'(e.chr));
    endtask

    task automatic wait_init_a(input string tag);
        int n;
        n = 0;
        while (!bus_a.init_done_o && n < 6000) begin
            tick();
            n++;
        end
        check(tag, n, DA);
    endtask

    task automatic ins_a(input int p, input int c, input string tag);
        bus_a.ins_valid_i  = 1'b1;
        bus_a.ins_prefix_i = CW'(p);
        bus_a.ins_char_i   = HW'(c);
        tick();
        bus_a.ins_valid_i = 1'b0;
        check({tag, ".done"}, 32'(bus_a.ins_done_o), 1);
        check({tag, ".code"}, 32'(bus_a.ins_code_o), exp_next);
        dict_m[exp_next] = '{valid: 1'b1, prefix: CW'(p), chr: HW'(c)};
        exp_next++;
        check({tag, ".next"}, 32'(bus_a.next_code_o), exp_next);
        check({tag, ".bits"}, 32'(bus_a.code_bits_o), cb_model(exp_next));
        tick();
        check({tag, ".done_drop"}, 32'(bus_a.ins_done_o), 0);
    endtask

    task automatic idle_bus_a();
        bus_a.clear_i = 1'b0; bus_a.rd_en_i = 1'b0; bus_a.rd_addr_i = '0;
        bus_a.ins_valid_i = 1'b0; bus_a.ins_prefix_i = '0; bus_a.ins_char_i = '0;
    endtask

    task automatic idle_bus_b();
        bus_b.clear_i = 1'b0; bus_b.rd_en_i = 1'b0; bus_b.rd_addr_i = '0;
        bus_b.ins_valid_i = 1'b0; bus_b.ins_prefix_i = '0; bus_b.ins_char_i = '0;
    endtask

    initial begin
        int n, p, c;
        dict_entry_t e;

        idle_bus_a();
        idle_bus_b();
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) tick();

        // Small instance: reset values, init length, fill to FULL.
        check("b_rst.init_done", 32'(bus_b.init_done_o), 0);
        check("b_rst.ready", 32'(bus_b.ins_ready_o), 0);
        check("b_rst.next", 32'(bus_b.next_code_o), LITERALS);
        check("b_rst.bits", 32'(bus_b.code_bits_o), HW + 1);
        check("b_rst.full", 32'(bus_b.full_o), 0);
        check("b_rst.done", 32'(bus_b.ins_done_o), 0);
        check("b_rst.code", 32'(bus_b.ins_code_o), 0);
        check("b_rst.hit", 32'(bus_b.rd_hit_o), 0);
        rst_b = 1'b0;
        n = 0;
        while (!bus_b.init_done_o && n < 1000) begin
            tick();
            n++;
        end
        check("b_init_len", n, DB);
        check("b_ready", 32'(bus_b.ins_ready_o), 1);

        dict_m.delete();
        exp_next = LITERALS;
        bus_b.ins_valid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            p = $urandom_range(0, exp_next - 1);
            c = $urandom_range(0, 255);
            bus_b.ins_prefix_i = CW'(p);
            bus_b.ins_char_i   = HW'(c);
            tick();
            if (exp_next < DB) begin
                check("b_ins.done", 32'(bus_b.ins_done_o), 1);
                check("b_ins.code", 32'(bus_b.ins_code_o), exp_next);
                dict_m[exp_next] = '{valid: 1'b1, prefix: CW'(p), chr: HW'(c)};
                exp_next++;
            end else begin
                check("b_full_ins.done", 32'(bus_b.ins_done_o), 0);
            end
            check("b_ins.next", 32'(bus_b.next_code_o), exp_next);
            check("b_ins.full", 32'(bus_b.full_o), 32'(exp_next == DB));
            check("b_ins.ready", 32'(bus_b.ins_ready_o), 32'(exp_next != DB));
            check("b_ins.bits", 32'(bus_b.code_bits_o), cb_model(exp_next));
        end
        bus_b.ins_valid_i = 1'b0;
        tick();
        check("b_full.done", 32'(bus_b.ins_done_o), 0);
        check("b_full.code_hold", 32'(bus_b.ins_code_o), DB - 1);
        rd_b(DB - 1, "b_rd_last");
        rd_b(DB, "b_rd_depth");
        rd_b(300, "b_rd_300");
        rd_b(65, "b_rd_65");

        // Default instance: reset, init walk length, literal reads.
        check("a_rst.init_done", 32'(bus_a.init_done_o), 0);
        check("a_rst.next", 32'(bus_a.next_code_o), LITERALS);
        check("a_rst.bits", 32'(bus_a.code_bits_o), HW + 1);
        check("a_rst.ready", 32'(bus_a.ins_ready_o), 0);
        rst_a = 1'b0;
        wait_init_a("a_init_len");
        dict_m.delete();
        exp_next = LITERALS;
        rd_a(65, "a_rd65", 1'b0);
        tick();
        check("a_rd_hold.char", 32'(bus_a.rd_char_o), 32'h41);
        rd_a(300, "a_rd300", 1'b0);

        // Single insert then read it back.
        ins_a(65, 66, "a_ins1");
        rd_a(256, "a_rd256", 1'b0);

        // Back-to-back random inserts across the 9->10 bit boundary.
        bus_a.ins_valid_i = 1'b1;
        for (int i = 0; i < 256; i++) begin
            p = $urandom_range(0, exp_next - 1);
            c = $urandom_range(0, 255);
            bus_a.ins_prefix_i = CW'(p);
            bus_a.ins_char_i   = HW'(c);
            tick();
            check("a_b2b.done", 32'(bus_a.ins_done_o), 1);
            check("a_b2b.code", 32'(bus_a.ins_code_o), exp_next);
            dict_m[exp_next] = '{valid: 1'b1, prefix: CW'(p), chr: HW'(c)};
            exp_next++;
            check("a_b2b.next", 32'(bus_a.next_code_o), exp_next);
            check("a_b2b.bits", 32'(bus_a.code_bits_o), cb_model(exp_next));
        end
        bus_a.ins_valid_i = 1'b0;
        for (int i = 0; i < 10; i++) rd_a($urandom_range(0, 700), "a_rd_rand", 1'b0);
        rd_a(DA - 1, "a_rd_top", 1'b0);

        // Read and insert at the same code: old contents come back.
        e = exp_entry(exp_next, DA);
        n = exp_next;
        bus_a.rd_en_i = 1'b1;
        bus_a.rd_addr_i = CW'(n);
        bus_a.ins_valid_i = 1'b1;
        bus_a.ins_prefix_i = CW'(7);
        bus_a.ins_char_i = 8'h99;
        tick();
        bus_a.rd_en_i = 1'b0;
        bus_a.ins_valid_i = 1'b0;
        check("a_rbw.hit", 32'(bus_a.rd_hit_o), 32'(e.valid));
        check("a_rbw.done", 32'(bus_a.ins_done_o), 1);
        dict_m[n] = '{valid: 1'b1, prefix: CW'(7), chr: 8'h99};
        exp_next++;
        rd_a(n, "a_rbw_reread", 1'b0);

        // Clear with a coincident insert: insert dropped, walk restarts.
        rd_a(65, "a_pre_clear", 1'b0);
        bus_a.clear_i = 1'b1;
        bus_a.ins_valid_i = 1'b1;
        tick();
        bus_a.clear_i = 1'b0;
        bus_a.ins_valid_i = 1'b0;
        check("a_clr.done", 32'(bus_a.ins_done_o), 0);
        check("a_clr.init_done", 32'(bus_a.init_done_o), 0);
        check("a_clr.next", 32'(bus_a.next_code_o), LITERALS);
        check("a_clr.bits", 32'(bus_a.code_bits_o), HW + 1);
        check("a_clr.ready", 32'(bus_a.ins_ready_o), 0);
        check("a_clr.rd_held", 32'(bus_a.rd_hit_o), 1);
        dict_m.delete();
        exp_next = LITERALS;
        wait_init_a("a_clr_init_len");
        rd_a(256, "a_clr_rd256", 1'b0);

        // Clear held high keeps the block in INIT.
        bus_a.clear_i = 1'b1;
        repeat (5) tick();
        check("a_hold_clr.init_done", 32'(bus_a.init_done_o), 0);
        check("a_hold_clr.next", 32'(bus_a.next_code_o), LITERALS);
        bus_a.clear_i = 1'b0;
        wait_init_a("a_hold_clr_init_len");

        // Reset mid-INIT: asynchronous return to reset values, walk restarts.
        rd_a(65, "a_pre_rst", 1'b0);
        bus_a.clear_i = 1'b1;
        tick();
        bus_a.clear_i = 1'b0;
        rd_a(65, "a_rd_in_init", 1'b1);
        repeat (100) tick();
        #2;
        rst_a = 1'b1;
        #1;
        check("a_midrst.init_done", 32'(bus_a.init_done_o), 0);
        check("a_midrst.next", 32'(bus_a.next_code_o), LITERALS);
        check("a_midrst.hit", 32'(bus_a.rd_hit_o), 0);
        tick();
        tick();
        rst_a = 1'b0;
        wait_init_a("a_midrst_init_len");
        rd_a(65, "a_post_rst", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
